// File: rtl/wb_regfile_sb_pkg.sv
// Shared definitions for the write-back register file and the decode/issue
// logic around it: default widths and the instruction opcode encoding.
package wb_regfile_sb_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int NUM_REGS_DEF   = 8;
  localparam int NUM_WB_DEF     = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_LW  = 3'd3,
    OP_SW  = 3'd4,
    OP_BEQ = 3'd5,
    OP_BNE = 3'd6
  } opcode_e;

  // Branches and stores never allocate a destination register.
  function automatic logic writes_dest(opcode_e op);
    return !(op inside {OP_SW, OP_BEQ, OP_BNE});
  endfunction

endpackage

// File: rtl/wb_regfile_sb_if.sv
// Bus bundle between the MEM/WB stage, decode, and the write-back register file.
interface wb_regfile_sb_if
  import wb_regfile_sb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_WB     = NUM_WB_DEF
);

  // wb_valid and issue_valid are single-cycle qualifiers with no backpressure:
  // each high cycle is exactly one transfer, taken on that rising clock edge.
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*REG_ADDR_W-1:0] wb_reg;
  logic [NUM_WB*DATA_W-1:0]     wb_data;
  logic                         issue_valid;
  logic [REG_ADDR_W-1:0]        issue_reg;
  logic [REG_ADDR_W-1:0]        rd_addr_a;
  logic [REG_ADDR_W-1:0]        rd_addr_b;
  logic [DATA_W-1:0]            rd_data_a;
  logic [DATA_W-1:0]            rd_data_b;
  logic                         rd_busy_a;
  logic                         rd_busy_b;
  logic [NUM_REGS*DATA_W-1:0]   regs_flat;
  logic [NUM_REGS-1:0]          busy_vec;
  logic                         bad_addr;

  modport master (
    output wb_valid, wb_reg, wb_data, issue_valid, issue_reg,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
    input  regs_flat, busy_vec, bad_addr
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, issue_valid, issue_reg,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
    output regs_flat, busy_vec, bad_addr
  );

endinterface

// File: rtl/wb_regfile_sb_priority_sel.sv
// For one register index, reports whether any valid write-back channel targets
// it and returns the data of the highest-index (youngest) such channel.
module wb_priority_sel
  import wb_regfile_sb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_WB     = NUM_WB_DEF
) (
  input  logic [REG_ADDR_W-1:0]        idx,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*REG_ADDR_W-1:0] wb_reg,
  input  logic [NUM_WB*DATA_W-1:0]     wb_data,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam logic [REG_ADDR_W:0] NREGS = (REG_ADDR_W+1)'(NUM_REGS);

  logic idx_ok;
  assign idx_ok = {1'b0, idx} < NREGS;

  // Ascending scan: a later (younger) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (idx_ok && wb_valid[i] && (wb_reg[i*REG_ADDR_W +: REG_ADDR_W] == idx)) begin
        hit  = 1'b1;
        data = wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/wb_regfile_sb.sv
// Multi-channel write-back register file with a pending-write scoreboard and
// two bypassed read ports for operand fetch and RAW hazard detection.
module wb_regfile_sb
  import wb_regfile_sb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_WB     = NUM_WB_DEF
) (
  input logic           clkwire,
  input logic           rst_n,
  wb_regfile_sb_if.slave bus
);

  localparam logic [REG_ADDR_W:0] NREGS = (REG_ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs        [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                bad;
  logic                bad_set;

  logic [NUM_REGS-1:0] wb_hit;
  logic [DATA_W-1:0]   wb_hit_data [NUM_REGS];
  logic [NUM_REGS-1:0] issue_hit;

  // Per-register write select: resolves same-cycle collisions by channel age.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(r);

    wb_priority_sel #(
      .DATA_W     (DATA_W),
      .NUM_REGS   (NUM_REGS),
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_WB     (NUM_WB)
    ) u_sel (
      .idx      (IDX),
      .wb_valid (bus.wb_valid),
      .wb_reg   (bus.wb_reg),
      .wb_data  (bus.wb_data),
      .hit      (wb_hit[r]),
      .data     (wb_hit_data[r])
    );

    assign issue_hit[r] = bus.issue_valid && (bus.issue_reg == IDX);
  end

  always_ff @(posedge clkwire or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wb_hit[r]) regs[r] <= wb_hit_data[r];
      end
    end
  end

  // The issuing instruction is younger than any write-back, so set beats clear.
  always_comb begin
    busy_next = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_next[r] = issue_hit[r] | (busy[r] & ~wb_hit[r]);
    end
  end

  always_comb begin
    bad_set = bus.issue_valid && ({1'b0, bus.issue_reg} >= NREGS);
    for (int i = 0; i < NUM_WB; i++) begin
      if (bus.wb_valid[i] && ({1'b0, bus.wb_reg[i*REG_ADDR_W +: REG_ADDR_W]} >= NREGS))
        bad_set = 1'b1;
    end
  end

  always_ff @(posedge clkwire or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      bad  <= 1'b0;
    end else begin
      busy <= busy_next;
      bad  <= bad | bad_set;
    end
  end

  // Read ports: index 0 is port A, index 1 is port B.
  logic [REG_ADDR_W-1:0] rd_addr   [2];
  logic [1:0]            rd_hit;
  logic [DATA_W-1:0]     rd_byp    [2];
  logic [DATA_W-1:0]     rd_stored [2];
  logic [1:0]            rd_sb;
  logic [1:0]            rd_ok;
  logic [DATA_W-1:0]     rd_data   [2];
  logic [1:0]            rd_busy;

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    wb_priority_sel #(
      .DATA_W     (DATA_W),
      .NUM_REGS   (NUM_REGS),
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_WB     (NUM_WB)
    ) u_sel (
      .idx      (rd_addr[p]),
      .wb_valid (bus.wb_valid),
      .wb_reg   (bus.wb_reg),
      .wb_data  (bus.wb_data),
      .hit      (rd_hit[p]),
      .data     (rd_byp[p])
    );
  end

  // Out-of-range addresses match no entry, so they read as zero and not busy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_stored[p] = '0;
      rd_sb[p]     = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_addr[p] == REG_ADDR_W'(r)) begin
          rd_stored[p] = regs[r];
          rd_sb[p]     = busy[r];
        end
      end
      rd_ok[p]   = {1'b0, rd_addr[p]} < NREGS;
      rd_data[p] = !rd_ok[p] ? '0 : (rd_hit[p] ? rd_byp[p] : rd_stored[p]);
      rd_busy[p] = rd_ok[p] &
                   ((rd_sb[p] & ~rd_hit[p]) |
                    (bus.issue_valid & (bus.issue_reg == rd_addr[p])));
    end
  end

  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  always_comb begin
    regs_flat = '0;
    for (int r = 0; r < NUM_REGS; r++) regs_flat[r*DATA_W +: DATA_W] = regs[r];
  end

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.rd_busy_a = rd_busy[0];
  assign bus.rd_busy_b = rd_busy[1];
  assign bus.regs_flat = regs_flat;
  assign bus.busy_vec  = busy;
  assign bus.bad_addr  = bad;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: default build plus a 1-channel,
// 16-register, 32-bit build sharing clock and reset.
module tb_wb_regfile_sb;

  logic clkwire = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clkwire = ~clkwire;

  wb_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8),  .REG_ADDR_W(4), .NUM_WB(2)) b0 ();
  wb_regfile_sb_if #(.DATA_W(32), .NUM_REGS(16), .REG_ADDR_W(4), .NUM_WB(1)) b1 ();

  wb_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .REG_ADDR_W(4), .NUM_WB(2)) u_dut0 (
    .clkwire (clkwire),
    .rst_n   (rst_n),
    .bus     (b0)
  );

  wb_regfile_sb #(.DATA_W(32), .NUM_REGS(16), .REG_ADDR_W(4), .NUM_WB(1)) u_dut1 (
    .clkwire (clkwire),
    .rst_n   (rst_n),
    .bus     (b1)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] exp0 [8];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] reg0(input int r);
    return b0.regs_flat[r*16 +: 16];
  endfunction

  function automatic logic [31:0] reg1(input int r);
    return b1.regs_flat[r*32 +: 32];
  endfunction

  task automatic check_regs0(input string tag);
    for (int r = 0; r < 8; r++) check($sformatf("%s_r%0d", tag, r), reg0(r), exp0[r]);
  endtask

  task automatic step();
    @(posedge clkwire);
    #1;
  endtask

  task automatic idle0();
    b0.wb_valid    = '0;
    b0.wb_reg      = '0;
    b0.wb_data     = '0;
    b0.issue_valid = 1'b0;
    b0.issue_reg   = '0;
  endtask

  initial begin
    idle0();
    b0.rd_addr_a   = '0;
    b0.rd_addr_b   = '0;
    b1.wb_valid    = '0;
    b1.wb_reg      = '0;
    b1.wb_data     = '0;
    b1.issue_valid = 1'b0;
    b1.issue_reg   = '0;
    b1.rd_addr_a   = '0;
    b1.rd_addr_b   = '0;
    for (int r = 0; r < 8; r++) exp0[r] = '0;

    repeat (3) @(posedge clkwire);
    #3 rst_n = 1'b1;
    #1;
    check_regs0("init");
    check("init_busy", b0.busy_vec, 8'h00);
    check("init_bad", b0.bad_addr, 1'b0);

    // Dual write on two channels
    b0.wb_valid = 2'b11;
    b0.wb_reg   = {4'd5, 4'd2};
    b0.wb_data  = {16'h2222, 16'h1111};
    step();
    idle0();
    exp0[2] = 16'h1111;
    exp0[5] = 16'h2222;
    check_regs0("dual");

    // Collision on reg3: channel 1 wins, also on the bypass path
    b0.wb_valid  = 2'b11;
    b0.wb_reg    = {4'd3, 4'd3};
    b0.wb_data   = {16'h5555, 16'hAAAA};
    b0.rd_addr_a = 4'd3;
    #1;
    check("coll_bypass", b0.rd_data_a, 16'h5555);
    step();
    idle0();
    exp0[3] = 16'h5555;
    check_regs0("coll");
    check("coll_read", b0.rd_data_a, 16'h5555);

    // Issue reg4: issue bypass, then registered busy
    b0.issue_valid = 1'b1;
    b0.issue_reg   = 4'd4;
    b0.rd_addr_a   = 4'd4;
    #1;
    check("issue_byp_busy", b0.rd_busy_a, 1'b1);
    step();
    idle0();
    check("issue_busy_vec", b0.busy_vec, 8'h10);
    check("issue_rd_busy", b0.rd_busy_a, 1'b1);

    // Write-back reg4 clears busy and bypasses data in the same cycle
    b0.wb_valid = 2'b01;
    b0.wb_reg   = {4'd0, 4'd4};
    b0.wb_data  = {16'h0000, 16'h0042};
    #1;
    check("wb4_bypass", b0.rd_data_a, 16'h0042);
    check("wb4_busy_clr", b0.rd_busy_a, 1'b0);
    step();
    idle0();
    exp0[4] = 16'h0042;
    check("wb4_busy_vec", b0.busy_vec, 8'h00);
    check_regs0("wb4");

    // Issue and write-back to reg4 in the same cycle: busy stays set
    b0.issue_valid = 1'b1;
    b0.issue_reg   = 4'd4;
    b0.wb_valid    = 2'b10;
    b0.wb_reg      = {4'd4, 4'd0};
    b0.wb_data     = {16'h0077, 16'h0000};
    #1;
    check("iswb_rd_busy", b0.rd_busy_a, 1'b1);
    check("iswb_bypass", b0.rd_data_a, 16'h0077);
    step();
    idle0();
    exp0[4] = 16'h0077;
    check("iswb_busy_vec", b0.busy_vec, 8'h10);
    check("iswb_reg4", reg0(4), exp0[4]);

    // Write-back to a non-busy register
    b0.wb_valid = 2'b01;
    b0.wb_reg   = {4'd0, 4'd6};
    b0.wb_data  = {16'h0000, 16'h0666};
    step();
    idle0();
    exp0[6] = 16'h0666;
    check("nb_busy_vec", b0.busy_vec, 8'h10);
    check("nb_reg6", reg0(6), exp0[6]);

    // Out-of-range write to reg9
    b0.wb_valid = 2'b01;
    b0.wb_reg   = {4'd0, 4'd9};
    b0.wb_data  = {16'h0000, 16'hFFFF};
    #1;
    check("oor_bad_pre", b0.bad_addr, 1'b0);
    step();
    idle0();
    check_regs0("oor");
    check("oor_bad", b0.bad_addr, 1'b1);
    repeat (3) step();
    check("oor_bad_sticky", b0.bad_addr, 1'b1);

    // Out-of-range read and issue on port B
    b0.rd_addr_b   = 4'd12;
    b0.issue_valid = 1'b1;
    b0.issue_reg   = 4'd12;
    #1;
    check("oor_rd_data", b0.rd_data_b, 16'h0000);
    check("oor_rd_busy", b0.rd_busy_b, 1'b0);
    step();
    idle0();
    check("oor_issue_busy", b0.busy_vec, 8'h10);

    // Asynchronous reset in mid-cycle with a pending write
    b0.wb_valid = 2'b01;
    b0.wb_reg   = {4'd0, 4'd1};
    b0.wb_data  = {16'h0000, 16'h0BAD};
    #2 rst_n = 1'b0;
    #1;
    for (int r = 0; r < 8; r++) exp0[r] = '0;
    check_regs0("rst");
    check("rst_busy", b0.busy_vec, 8'h00);
    check("rst_bad", b0.bad_addr, 1'b0);
    @(posedge clkwire);
    #1;
    check_regs0("rst_hold");
    idle0();
    #2 rst_n = 1'b1;
    step();
    check_regs0("post_rst");

    // 1-channel, 16-register, 32-bit build
    b1.wb_valid  = 1'b1;
    b1.wb_reg    = 4'd15;
    b1.wb_data   = 32'hDEADBEEF;
    b1.rd_addr_a = 4'd15;
    #1;
    check("p_bypass", b1.rd_data_a, 32'hDEADBEEF);
    check("p_bypass_busy", b1.rd_busy_a, 1'b0);
    step();
    b1.wb_valid = 1'b0;
    check("p_reg15", reg1(15), 32'hDEADBEEF);
    check("p_read15", b1.rd_data_a, 32'hDEADBEEF);

    b1.issue_valid = 1'b1;
    b1.issue_reg   = 4'd9;
    step();
    b1.issue_valid = 1'b0;
    b1.rd_addr_b   = 4'd9;
    #1;
    check("p_busy_vec", b1.busy_vec, 16'h0200);
    check("p_rd_busy", b1.rd_busy_b, 1'b1);

    b1.wb_valid = 1'b1;
    b1.wb_reg   = 4'd9;
    b1.wb_data  = 32'h12345678;
    #1;
    check("p_wb9_bypass", b1.rd_data_b, 32'h12345678);
    check("p_wb9_busy", b1.rd_busy_b, 1'b0);
    step();
    b1.wb_valid = 1'b0;
    check("p_wb9_vec", b1.busy_vec, 16'h0000);
    check("p_reg9", reg1(9), 32'h12345678);
    check("p_bad", b1.bad_addr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
- Parametrised write-back register file: the next generation of the pipeline write-back stage.
- Accepts NUM_WB independent write-back channels per cycle and keeps the architectural register state internally; no external register loop-back.
- Adds a pending-write scoreboard (set at issue, cleared at write-back) and two bypassed read ports, so decode can read operands and detect RAW hazards.
- Sits between the MEM/WB pipeline register and the decode stage.

Parameters:
- DATA_W, 16, register data width
- NUM_REGS, 8, number of architectural registers (2..16)
- REG_ADDR_W, 4, register-number width; must satisfy 2**REG_ADDR_W >= NUM_REGS
- NUM_WB, 2, number of write-back channels (1..4); higher index = younger instruction

Ports:
- clkwire  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  NUM_WB  per-channel write enable
- wb_reg  in  NUM_WB*REG_ADDR_W  per-channel destination register, packed, channel 0 at LSBs
- wb_data  in  NUM_WB*DATA_W  per-channel write data, packed, channel 0 at LSBs
- issue_valid  in  1  instruction with a destination issued this cycle
- issue_reg  in  REG_ADDR_W  destination of the issued instruction
- rd_addr_a  in  REG_ADDR_W  read port A address
- rd_addr_b  in  REG_ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data, bypassed
- rd_data_b  out  DATA_W  read port B data, bypassed
- rd_busy_a  out  1  port A register has a pending write
- rd_busy_b  out  1  port B register has a pending write
- regs_flat  out  NUM_REGS*DATA_W  all register contents, reg 0 at LSBs, registered
- busy_vec  out  NUM_REGS  scoreboard bits, registered
- bad_addr  out  1  sticky flag: out-of-range register number seen

Behaviour:
- Reset is asynchronous on rst_n low. All registers = 0, busy_vec = 0, bad_addr = 0. Reset while writes are in flight discards them.
- Write timing: on a rising clkwire with wb_valid[i]=1 and wb_reg[i] < NUM_REGS, reg[wb_reg[i]] <= wb_data[i]. The value is visible on regs_flat the next cycle.
- Same-cycle collision (two channels, same register): the highest-index valid channel wins. Lower channels to that register are dropped.
- Scoreboard set/clear: issue_valid with issue_reg < NUM_REGS sets busy[issue_reg]. A valid in-range write-back clears busy[wb_reg[i]].
- Issue and write-back to the same register in the same cycle: busy ends set, because the issue is younger.
- A write-back to a non-busy register is legal; it writes the data and busy stays 0.
- Reads are combinational from the register array plus bypass.
  - If any valid in-range channel targets rd_addr this cycle, rd_data returns that channel's wb_data (highest index wins). Otherwise it returns the stored value.
  - rd_busy = busy[rd_addr] & ~(write-back to rd_addr this cycle) | (issue_valid & issue_reg == rd_addr).
- Out-of-range handling: for any address >= NUM_REGS, writes and issues are ignored and bad_addr is set (sticky until reset). Out-of-range reads return 0 with rd_busy = 0 and do not set bad_addr.
- No registers are hardwired to zero.
- Latency: write to regs_flat, 1 cycle; write to rd_data, 0 cycles (bypass).
- No simulation-only $display in the synthesised path.

Decomposition:
- Shared package: DATA_W/REG_ADDR_W defaults and the opcode constants (ADD=0, SUB=1, MUL=2, LW=3, SW=4, BEQ=5, BNE=6), reused by decode/issue.
- One natural sub-module, wb_priority_sel: for a given register index, returns hit and the data of the highest-index matching valid channel. It is instantiated per register and per read port.

Test Plan:
- Reset: drive values, then assert rst_n=0 mid-cycle -> regs_flat=0, busy_vec=0, bad_addr=0 immediately, with no clock needed.
- Dual write: ch0 reg2=0x1111, ch1 reg5=0x2222 -> next cycle reg2=0x1111, reg5=0x2222, all others unchanged.
- Collision: ch0 and ch1 both write reg3, data 0xAAAA/0x5555 -> reg3=0x5555.
- Scoreboard:
  - Issue reg4 -> busy_vec[4]=1 next cycle.
  - rd_addr_a=4 -> rd_busy_a=1.
  - Write-back reg4=0x0042 -> rd_data_a=0x0042 and rd_busy_a=0 in that same cycle; busy_vec[4]=0 next cycle.
  - Issue and write-back reg4 in the same cycle -> busy_vec[4] stays 1.
- Out-of-range: NUM_REGS=8, write reg 9 data 0xFFFF -> no register changes, bad_addr=1 and stays 1. rd_addr_b=12 -> rd_data_b=0, rd_busy_b=0.
- Parameter sweep: NUM_WB=1, NUM_REGS=16, DATA_W=32 -> write/read/bypass scenarios pass unchanged.
